// File: rtl/serdes_link_arbiter_pkg.sv
// Shared types and helpers for the serializer link arbiter.
// Grant FSM encoding plus the packed-bus slice helper.
package serdes_link_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Low bit of channel idx inside a bus of width-bit words.
  function automatic int slice_base(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first request at or after ptr+1, wrapping.
// The request vector is doubled so that the wrap becomes a plain lowest-bit search.
module rr_priority_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] winner
);

  localparam int PW = $clog2(N);

  logic [PW-1:0]  start;
  logic [N-1:0]   low_mask;
  logic [2*N-1:0] dbl_req;

  assign start = (ptr == PW'(N - 1)) ? '0 : ptr + 1'b1;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
      assign low_mask[gi] = (PW'(gi) >= start);
    end
  endgenerate

  // Lower copy holds requests at/after start, upper copy covers the wrap.
  assign dbl_req = {req, req & low_mask};

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (dbl_req[i]) begin
        found  = 1'b1;
        winner = PW'(i % N);
      end
    end
  end

endmodule

// File: rtl/serdes_link_arbiter.sv
// Round-robin burst arbiter feeding one serializer wide-side input.
// Grants a source for up to MAX_BURST words through a one-entry output register.
module serdes_link_arbiter
  import serdes_link_arbiter_pkg::*;
#(
  parameter int NUM_CHANNELS   = 4,
  parameter int HUB_FIFO_WIDTH = 32,
  parameter int MAX_BURST      = 4,
  parameter int ID_WIDTH       = $clog2(NUM_CHANNELS)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS-1:0]                channel_enable,
  input  logic [NUM_CHANNELS*HUB_FIFO_WIDTH-1:0] in_data,
  input  logic [NUM_CHANNELS-1:0]                in_valid,
  output logic [NUM_CHANNELS-1:0]                in_ready,
  output logic [HUB_FIFO_WIDTH-1:0]              out_data,
  output logic [ID_WIDTH-1:0]                    out_id,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t                state_reg;
  logic [ID_WIDTH-1:0]       owner_reg;
  logic [ID_WIDTH-1:0]       rr_ptr_reg;
  logic [CW-1:0]             burst_cnt_reg;
  logic [CW-1:0]             burst_cnt_next;
  logic [HUB_FIFO_WIDTH-1:0] out_data_reg;
  logic [ID_WIDTH-1:0]       out_id_reg;
  logic                      out_valid_reg;

  logic                      load_en;
  logic                      pick_found;
  logic [ID_WIDTH-1:0]       pick_winner;
  logic                      accept;
  logic [ID_WIDTH-1:0]       sel_id;
  logic [HUB_FIFO_WIDTH-1:0] sel_data;

  assign load_en        = !out_valid_reg | out_ready;
  assign burst_cnt_next = burst_cnt_reg + 1'b1;

  rr_priority_picker #(
    .N (NUM_CHANNELS)
  ) u_picker (
    .req    (in_valid & channel_enable),
    .ptr    (rr_ptr_reg),
    .found  (pick_found),
    .winner (pick_winner)
  );

  always_comb begin
    in_ready = '0;
    accept   = 1'b0;
    sel_id   = owner_reg;
    if (reset) begin
      if (state_reg == IDLE) begin
        if (pick_found && load_en) begin
          in_ready[pick_winner] = 1'b1;
          sel_id                = pick_winner;
          accept                = 1'b1;
        end
      end else begin
        // Ready is offered to the owner regardless of its valid.
        in_ready[owner_reg] = load_en & channel_enable[owner_reg];
        accept              = in_ready[owner_reg] & in_valid[owner_reg];
      end
    end
  end

  assign sel_data = in_data[slice_base(int'(sel_id), HUB_FIFO_WIDTH) +: HUB_FIFO_WIDTH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      owner_reg     <= '0;
      rr_ptr_reg    <= ID_WIDTH'(NUM_CHANNELS - 1);
      burst_cnt_reg <= '0;
      out_data_reg  <= '0;
      out_id_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else if (load_en) begin
      out_valid_reg <= accept;
      if (accept) begin
        out_data_reg <= sel_data;
        out_id_reg   <= sel_id;
      end
      if (state_reg == IDLE) begin
        if (accept) begin
          owner_reg     <= sel_id;
          rr_ptr_reg    <= sel_id;
          burst_cnt_reg <= CW'(1);
          state_reg     <= (MAX_BURST > 1) ? BURST : IDLE;
        end
      end else if (accept) begin
        burst_cnt_reg <= burst_cnt_next;
        if (burst_cnt_next == CW'(MAX_BURST)) state_reg <= IDLE;
      end else begin
        // Owner dropped valid or was disabled: give up the grant.
        state_reg <= IDLE;
      end
    end
  end

  assign out_data  = out_data_reg;
  assign out_id    = out_id_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg == BURST) | out_valid_reg;

endmodule

// File: doc/serdes_link_arbiter.md
# serdes_link_arbiter

Round-robin arbiter that shares one serializer wide-side input among `NUM_CHANNELS` wide-FIFO requesters. It sits between the per-source hub FIFOs and a single `serializer`. It grants one source at a time for a bounded burst of words and forwards each word with its source id through a one-entry registered output stage. This keeps a source's consecutive words contiguous on the narrow link and guarantees every enabled source service within a bounded number of words.

## Interface
Parameters:
- `NUM_CHANNELS`, 4: number of requesters; must be ≥2.
- `HUB_FIFO_WIDTH`, 32: word width, same as the serializer wide side.
- `MAX_BURST`, 4: maximum consecutive words per grant; must be ≥1.
- `ID_WIDTH`, `$clog2(NUM_CHANNELS)`: source id width.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `channel_enable`  in  NUM_CHANNELS  per-channel enable; a disabled channel is never granted.
- `in_data`  in  NUM_CHANNELS*HUB_FIFO_WIDTH  packed words; channel i occupies bits [i*W +: W].
- `in_valid`  in  NUM_CHANNELS  per-channel valid.
- `in_ready`  out  NUM_CHANNELS  per-channel ready; at most one bit high in any cycle.
- `out_data`  out  HUB_FIFO_WIDTH  word to the serializer `wide_fifo_data`.
- `out_id`  out  ID_WIDTH  source id of `out_data`.
- `out_valid`  out  1  to the serializer `wide_fifo_valid`.
- `out_ready`  in  1  from the serializer `wide_fifo_ready`.
- `busy`  out  1  high while in BURST or while `out_valid` is high.

## Operation
- A transfer on channel i occurs when `in_valid[i] & in_ready[i]`. An output transfer occurs when `out_valid & out_ready`.
- `load_en = !out_valid | out_ready`. The output register accepts a new word only when `load_en` is high.
- Registers: `state` {IDLE, BURST}, `owner`, `rr_ptr` (last winner), `burst_cnt` (width `$clog2(MAX_BURST+1)`), plus the output register.
- IDLE:
  - The winner is the first channel with `in_valid & channel_enable`, scanning from `rr_ptr+1` modulo N.
  - If a winner exists and `load_en` is high: `in_ready[winner]=1`, the word is captured, `owner<=winner`, `rr_ptr<=winner`, `burst_cnt<=1`.
  - Next state is BURST if `MAX_BURST>1`, otherwise IDLE.
  - If no winner exists, all `in_ready` are 0 and the state stays IDLE.
- BURST:
  - `in_ready[owner] = load_en & channel_enable[owner]`.
  - On a transfer: `burst_cnt++`. When the new count equals `MAX_BURST`, go to IDLE.
  - If `in_valid[owner]` or `channel_enable[owner]` is low: no transfer, go to IDLE next cycle. This costs one bubble cycle.
  - If `load_en` is low: hold all state.
- Output register: when `load_en` is high and a word is accepted, `out_data`/`out_id` are loaded and `out_valid<=1`. When `load_en` is high and no word is accepted, `out_valid<=0`.
- `channel_enable` deasserting for a non-owner has no effect beyond excluding it from arbitration. Deasserting it for the owner ends the burst as above. A word already in the output register is still delivered.

## Timing
- Reset values: `out_valid=0`, `in_ready=0`, `busy=0`, `state=IDLE`, `rr_ptr=NUM_CHANNELS-1` so channel 0 wins first, `burst_cnt=0`. `out_data`/`out_id` are don't-care.
- While `reset` is low, all `in_ready` are forced 0.
- Reset asserted mid-burst discards the output word and returns to the reset state on the next edge. No partial state survives.
- Latency: input accept at edge n gives `out_valid` high after edge n.
- Throughput: with `out_ready` held high, one word per cycle, including across grant hand-off from IDLE.
- Full: while `out_valid & !out_ready`, all `in_ready` are 0 and the output is stable.
- Bubbles: one bubble cycle occurs when the owner drops valid mid-burst.
- Round-robin wrap: the pointer wraps from N-1 to 0. With all channels requesting, the grant order is 0,1,…,N-1,0.
- `in_ready` is combinational from `state`, `owner`, `in_valid`, `channel_enable`, `out_valid` and `out_ready`. It has no combinational path from `in_data`.

## Structure
- Package `serdes_link_arbiter_pkg`:
  - `arb_state_t` enum {IDLE, BURST}.
  - A function for the packed-array slice index.
- Sub-module `rr_priority_picker`:
  - Parameter `N`.
  - Inputs: request vector, pointer.
  - Outputs: `found`, `winner` index.
  - Purely combinational, using a double-width mask-and-priority scheme.
- Top level holds the FSM, counters and output register.

## Test plan
- Reset, then all 4 channels valid, `out_ready=1`, `MAX_BURST=4` -> `out_id` sequence 0,0,0,0,1,1,1,1,2…; one word per cycle; data matches per-channel counters.
- Channel 2 alone sends 2 words then drops valid -> 2 output words with `out_id=2`, one bubble cycle, state returns to IDLE, `busy` falls after the last output transfer.
- `out_ready=0` for 5 cycles with channel 1 valid -> `out_valid=1`, `out_data` and `out_id` held, all `in_ready=0`; the first word is delivered on the release cycle, followed by the next.
- `channel_enable=4'b1011`, all channels valid -> channel 2 never granted; order is 0,1,3,0.
- Reset pulled low mid-burst on channel 3 -> next cycle `out_valid=0`, `in_ready=0`; after release, channel 0 wins first.
- `MAX_BURST=1`, all channels valid -> `out_id` rotates 0,1,2,3,0 every cycle with no bubbles.
